// File: rtl/press_sched_pkg.sv
// Shared types and constants for the floor-call press scheduler.
// Combinational only; no latency or backpressure.
package press_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam int FLOOR_W_DEF = 3;
    localparam int DROP_CNT_W  = 8;
    localparam int GAP_W       = 9;

    typedef struct packed {
        logic [FLOOR_W_DEF-1:0] floor;
        logic                   dir;
    } call_t;

    // The bottom floor can only be called upward, the top floor only downward.
    function automatic logic fix_dir(input logic at_bottom, input logic at_top, input logic req_up);
        logic dir;
        dir = req_up;
        if (at_bottom) dir = 1'b1;
        else if (at_top) dir = 1'b0;
        return dir;
    endfunction

endpackage

// File: rtl/press_scheduler_if.sv
// Call handshake between the press scheduler (master) and the elevator controller (slave).
// Plain valid/ready bundle; no latency of its own.
interface press_call_if #(
    parameter int FLOOR_W = 3
);
    logic               call_valid;
    logic               call_ready;
    logic [FLOOR_W-1:0] call_floor;
    logic               call_dir;

    modport master (
        output call_valid,
        output call_floor,
        output call_dir,
        input  call_ready
    );

    modport slave (
        input  call_valid,
        input  call_floor,
        input  call_dir,
        output call_ready
    );
endinterface

// File: rtl/press_fifo.sv
// Small synchronous FIFO; a push is visible at the head one cycle later (no bypass).
// A push when full is accepted only if a pop frees a slot in the same cycle.
module press_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop_vld && !empty;
    assign push_ok = push_vld && (!full || pop_ok);

    // When empty the head repeats the last entry that was presented.
    assign head_dat = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (!empty)  hold_d   = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/press_scheduler.sv
// Paces rng samples into floor-call presses, drops duplicates/overflow, queues them for the controller.
// SAMPLE to call_valid is 1 cycle; call_ready low only fills the queue. Macro PRESS_SCHED_DEDUP_EN enables duplicate suppression.
module press_scheduler
    import press_sched_pkg::*;
#(
    parameter  int NUM_FLOORS = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int MIN_GAP    = 16,
    localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [11:0]           rand_in,
    press_call_if.master          call_if,
    input  logic                  svc_valid,
    input  logic [FLOOR_W-1:0]    svc_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    state_t                  state_q, state_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [FLOOR_W-1:0]      smp_floor;
    logic                    smp_dir;
    logic                    sample_now;
    logic                    is_dup;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FLOOR_W:0]        head_dat;
    logic                    unused_rand;

    assign unused_rand = ^rand_in;

    assign smp_floor  = rand_in[FLOOR_W-1:0];
    assign smp_dir    = fix_dir(smp_floor == '0,
                                smp_floor == FLOOR_W'(NUM_FLOORS - 1),
                                rand_in[FLOOR_W]);
    assign sample_now = (state_q == SAMPLE) && en;

`ifdef PRESS_SCHED_DEDUP_EN
    // A same-cycle service of this floor counts as already cleared.
    assign is_dup = pending_q[smp_floor] && !(svc_valid && (svc_floor == smp_floor));
`else
    assign is_dup = 1'b0;
`endif

    assign pop  = !fifo_empty && call_if.call_ready;
    assign push = sample_now && !is_dup && (!fifo_full || pop);
    assign drop = sample_now && !push;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = WAIT;
                    gap_d   = GAP_W'(MIN_GAP);
                end
            end
            WAIT: begin
                if (!en) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else if (gap_q <= GAP_W'(1)) begin
                    state_d = SAMPLE;
                    gap_d   = '0;
                end else begin
                    gap_d   = gap_q - GAP_W'(1);
                end
            end
            SAMPLE: begin
                if (!en) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    state_d = WAIT;
                    gap_d   = GAP_W'(MIN_GAP) + GAP_W'(rand_in[11:8]);
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
    end

    // Service clears first so a same-floor enqueue in the same cycle wins.
    always_comb begin
        pending_d  = pending_q;
        drop_cnt_d = drop_cnt_q;
        if (svc_valid) pending_d[svc_floor] = 1'b0;
        if (push)      pending_d[smp_floor] = 1'b1;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            pending_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    press_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FLOOR_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push_vld (push),
        .push_dat ({smp_floor, smp_dir}),
        .pop_vld  (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_dat)
    );

    assign call_if.call_valid = !fifo_empty;
    assign call_if.call_floor = head_dat[FLOOR_W:1];
    assign call_if.call_dir   = head_dat[0];
    assign pending            = pending_q;
    assign drop_cnt           = drop_cnt_q;

endmodule

// File: doc/press_scheduler.md
Name: press_scheduler

Overview:
- Turns the free-running 12-bit rng word into a paced stream of simulated floor-call button presses for the elevator controller.
- Samples the rng at randomized intervals and decodes each sample into a floor and direction.
- Drops duplicate or overflow presses, queues accepted calls in a small FIFO, and hands them out over a valid/ready handshake.
- Sits between the rng and the controller's call input.

Parameters:
- NUM_FLOORS, 8: number of floors; must be a power of two, range 2..16; FLOOR_W = $clog2(NUM_FLOORS).
- FIFO_DEPTH, 4: number of call queue entries; must be a power of two.
- MIN_GAP, 16: minimum WAIT length in cycles; range 1..255.

Ports:
- clk  in  1  system clock (~750 kHz).
- rst  in  1  asynchronous, active-low reset.
- en  in  1  press generation enable.
- rand_in  in  12  rng output word.
- call_valid  out  1  FIFO head is valid.
- call_ready  in  1  controller accepts the head entry.
- call_floor  out  FLOOR_W  head entry floor.
- call_dir  out  1  head entry direction; 1 = up, 0 = down.
- svc_valid  in  1  controller has serviced a floor this cycle.
- svc_floor  in  FLOOR_W  the serviced floor.
- pending  out  NUM_FLOORS  per-floor outstanding-call mask.
- drop_cnt  out  8  count of dropped presses; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, gap counter 0, FIFO empty, call_valid=0, call_floor=0, call_dir=0, pending=0, drop_cnt=0.
- FSM states: IDLE, WAIT, SAMPLE.
  - IDLE: when en=1, load gap counter with MIN_GAP and go to WAIT next cycle.
  - WAIT: decrement the counter each cycle. WAIT lasts exactly the loaded number of cycles, then go to SAMPLE.
  - SAMPLE: lasts one cycle and evaluates rand_in. Then go to WAIT with the counter loaded with MIN_GAP + rand_in[11:8] (9-bit add, no wrap). Sample-to-sample period is gap+1 cycles.
- en=0 in WAIT or SAMPLE: go to IDLE next cycle; no press is evaluated that cycle; counter is cleared. FIFO contents and pending are retained, and draining continues.
- Decode at SAMPLE:
  - floor = rand_in[FLOOR_W-1:0]; dir = rand_in[FLOOR_W].
  - Override: floor 0 forces dir=1; floor NUM_FLOORS-1 forces dir=0.
- Accept/drop at SAMPLE:
  - Evaluate the service clear first: if svc_valid && svc_floor==floor in the same cycle, treat pending[floor] as 0.
  - Drop if pending[floor]=1 (duplicate), or if the FIFO is full and no pop occurs this cycle.
  - Drop increments drop_cnt, saturating at 255.
  - Otherwise enqueue {floor,dir} and set pending[floor]. The entry is visible at the FIFO output the next cycle.
- FIFO: first-in first-out. call_valid = !empty; the head appears on call_floor/call_dir.
  - Pop on call_valid && call_ready.
  - Push and pop in the same cycle is legal at any occupancy, including full and empty+push (new entry is not bypassed; visible next cycle).
  - call_floor/call_dir hold their last value when empty.
- pending:
  - Cleared by svc_valid for svc_floor on the next edge, regardless of whether that call is still queued.
  - Set from an enqueue on the same floor in the same cycle wins over a clear.
  - svc_valid for a floor that is not pending has no effect.
- Latency: SAMPLE to call_valid rising (empty FIFO) = 1 cycle.

Optional Feature:
- Macro: PRESS_SCHED_DEDUP_EN.
- Defined: duplicate suppression as above.
- Undefined: the pending check is skipped, and presses to already-pending floors are enqueued. pending is still set and cleared. Drops then occur only on FIFO full.

Decomposition:
- press_sched_pkg holds:
  - state_t enum {IDLE, WAIT, SAMPLE}.
  - call_t packed struct {floor, dir}, with the floor width derived via a package localparam default of 3.
  - DROP_CNT_W = 8.
- Sub-module press_fifo: parameterized depth/width synchronous FIFO with push/pop/full/empty/head.
  - Pointers are one bit wider than the address.
  - Simultaneous push+pop keeps the count unchanged.

Test Plan:
- Reset, then en=1 with rand_in=12'h000 held → first SAMPLE at cycle 17 after en. Entry floor0/up is enqueued and call_valid=1 the following cycle; pending=8'h01.
- Second sample with rand_in=12'h000, call_ready=0 → duplicate dropped; drop_cnt=1; FIFO count stays 1 (with DEDUP_EN). Without the macro, count=2.
- rand_in=12'h40F (floor 7, bit3=1 requests up) → enqueued as floor7/down. Next gap = 16+4 = 20 cycles of WAIT, measured between consecutive SAMPLEs as 21.
- call_ready=0, feed 5 distinct floors (1,2,3,4,5) → first 4 queued, 5th dropped; drop_cnt=1. Then call_ready=1 → floors pop in order 1,2,3,4 on consecutive cycles.
- Full FIFO with call_ready=1 on the SAMPLE cycle of a new floor 6 → push accepted; no drop.
- svc_valid with svc_floor=2 in the SAMPLE cycle of floor 2, which is pending → press accepted; pending[2] remains 1.
- Assert rst=0 mid-WAIT with 3 queued entries → same-cycle asynchronous clear: call_valid=0, pending=0, drop_cnt=0, state IDLE.
